// File: rtl/mac_lane_array.sv
// Pipelined multi-lane multiply-accumulate: product, lane reduction and window accumulation
// stages, with a single valid/ready result register that back-pressures the whole pipe.
module mac_lane_array #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Lanes     = 4,
    parameter int unsigned AccWidth  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         signed_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [Lanes*DataWidth-1:0]   m1,
    input  logic [Lanes*DataWidth-1:0]   m2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [AccWidth-1:0]          acc_out
);

    localparam int unsigned ProdWidth = 2 * DataWidth;

    logic                 stall;
    logic                 accept;

    logic [ProdWidth-1:0] prod_d [Lanes];
    logic [ProdWidth-1:0] prod_q [Lanes];
    logic                 s1_valid_q;
    logic                 s1_last_q;
    logic                 s1_signed_q;

    logic [AccWidth-1:0]  ext [Lanes];
    logic [AccWidth-1:0]  s2_sum_d;
    logic [AccWidth-1:0]  s2_sum_q;
    logic                 s2_valid_q;
    logic                 s2_last_q;

    logic [AccWidth-1:0]  acc_q;
    logic [AccWidth-1:0]  sum_acc;
    logic [AccWidth-1:0]  acc_out_q;
    logic                 out_valid_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < Lanes; i++) begin : g_lane
        logic [DataWidth-1:0]        op_a;
        logic [DataWidth-1:0]        op_b;
        logic signed [ProdWidth-1:0] prod_s;
        logic [ProdWidth-1:0]        prod_u;

        assign op_a   = m1[i*DataWidth +: DataWidth];
        assign op_b   = m2[i*DataWidth +: DataWidth];
        assign prod_s = $signed(op_a) * $signed(op_b);
        assign prod_u = op_a * op_b;
        assign prod_d[i] = signed_mode ? prod_s : prod_u;

        // Each beat carries its own mode, so extension follows the stage-1 tag.
        assign ext[i] = s1_signed_q ? AccWidth'($signed(prod_q[i])) : AccWidth'(prod_q[i]);
    end

    always_comb begin
        s2_sum_d = '0;
        for (int i = 0; i < Lanes; i++) begin
            s2_sum_d = s2_sum_d + ext[i];
        end
    end

    assign sum_acc = acc_q + s2_sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Lanes; i++) begin
                prod_q[i] <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_signed_q <= 1'b0;
            s2_sum_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            for (int i = 0; i < Lanes; i++) begin
                prod_q[i] <= prod_d[i];
            end
            s1_valid_q  <= accept;
            s1_last_q   <= in_last;
            s1_signed_q <= signed_mode;
            s2_sum_q    <= s2_sum_d;
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            // Not stalled means any pending result is being taken this edge.
            out_valid_q <= s2_valid_q && s2_last_q;
            if (s2_valid_q) begin
                if (s2_last_q) begin
                    acc_out_q <= sum_acc;
                    acc_q     <= '0;
                end else begin
                    acc_q     <= sum_acc;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;

endmodule

// File: tb/tb_mac_lane_array.sv
// Directed-vector bench for mac_lane_array: a 32-bit and an 18-bit accumulator instance
// share stimulus; a negedge monitor records every accepted result for later checks.
module tb_mac_lane_array;

    logic        clk;
    logic        rst;
    logic        signed_mode;
    logic        in_valid;
    logic        in_last;
    logic [31:0] m1;
    logic [31:0] m2;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] acc_out;
    logic        in_ready18;
    logic        out_valid18;
    logic [17:0] acc_out18;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [31:0] q1 [$];
    int          q1c [$];
    logic [31:0] q2 [$];

    mac_lane_array #(.DataWidth(8), .Lanes(4), .AccWidth(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_mode(signed_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .m1         (m1),
        .m2         (m2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc_out    (acc_out)
    );

    mac_lane_array #(.DataWidth(8), .Lanes(4), .AccWidth(18)) dut18 (
        .clk        (clk),
        .rst        (rst),
        .signed_mode(signed_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready18),
        .in_last    (in_last),
        .m1         (m1),
        .m2         (m2),
        .out_valid  (out_valid18),
        .out_ready  (out_ready),
        .acc_out    (acc_out18)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst && out_valid && out_ready) begin
            q1.push_back(acc_out);
            q1c.push_back(cyc);
        end
        if (!rst && out_valid18 && out_ready) begin
            q2.push_back({14'd0, acc_out18});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d (0x%08h), expected %0d (0x%08h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] l0, input logic [7:0] l1,
                                       input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                        input logic sgn);
        int guard;
        in_valid    = 1'b1;
        m1          = a;
        m2          = b;
        in_last     = last;
        signed_mode = sgn;
        guard       = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_eq("send_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_q1(input int n, input string tag);
        int guard = 0;
        while (q1.size() < n && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check_eq(tag, 32'(q1.size()), 32'(n));
    endtask

    task automatic clear_q();
        q1.delete();
        q1c.delete();
        q2.delete();
    endtask

    initial begin
        logic [31:0] ones;
        logic [31:0] ten_a;
        logic [31:0] unit;
        logic [31:0] sev;
        int guard;

        ones  = pk(8'd255, 8'd255, 8'd255, 8'd255);
        ten_a = pk(8'd1, 8'd2, 8'd3, 8'd4);
        unit  = pk(8'd1, 8'd1, 8'd1, 8'd1);
        sev   = pk(8'd7, 8'd0, 8'd0, 8'd0);

        rst         = 1'b1;
        signed_mode = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        m1          = '0;
        m2          = '0;
        out_ready   = 1'b1;

        @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_acc_out", acc_out, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Unsigned full-scale single-beat window; result visible at the third
        // negedge after the accepting edge.
        clear_q();
        in_valid = 1'b1; in_last = 1'b1; signed_mode = 1'b0; m1 = ones; m2 = ones;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check_eq("lat_edge1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check_eq("lat_edge2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check_eq("lat_edge3", {31'd0, out_valid}, 32'd1);
        check_eq("full_scale", acc_out, 32'd260100);
        @(negedge clk);
        check_eq("ov_clears", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Signed two-beat window.
        clear_q();
        send(pk(8'h80, 8'd1, 8'd0, 8'd0), pk(8'd127, 8'd1, 8'd0, 8'd0), 1'b0, 1'b1);
        send(pk(8'hFF, 8'd0, 8'd0, 8'd0), pk(8'hFF, 8'd0, 8'd0, 8'd0), 1'b1, 1'b1);
        wait_q1(1, "signed_count");
        check_eq("signed_sum", (q1.size() > 0) ? q1[0] : 32'hDEADBEEF, 32'hFFFFC082);

        // Back-to-back windows: 3 x 10 then 2 x 7 with no bubble.
        @(posedge clk);
        #1;
        clear_q();
        send(ten_a, unit, 1'b0, 1'b0);
        send(ten_a, unit, 1'b0, 1'b0);
        send(ten_a, unit, 1'b1, 1'b0);
        send(sev, unit, 1'b0, 1'b0);
        send(sev, unit, 1'b1, 1'b0);
        wait_q1(2, "b2b_count");
        check_eq("b2b_first", (q1.size() > 0) ? q1[0] : 32'hDEADBEEF, 32'd30);
        check_eq("b2b_second", (q1.size() > 1) ? q1[1] : 32'hDEADBEEF, 32'd14);
        check_eq("b2b_spacing", (q1c.size() > 1) ? 32'(q1c[1] - q1c[0]) : 32'hDEADBEEF,
                 32'd2);

        // Backpressure: first result held for 5 cycles, second window queued behind it.
        @(posedge clk);
        #1;
        clear_q();
        out_ready = 1'b0;
        send(ten_a, unit, 1'b1, 1'b0);
        send(sev, unit, 1'b0, 1'b0);
        send(sev, unit, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
            check_eq($sformatf("bp_hold_%0d", i), acc_out, 32'd10);
        end
        check_eq("bp_ov_held", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_q1(2, "bp_count");
        check_eq("bp_first", (q1.size() > 0) ? q1[0] : 32'hDEADBEEF, 32'd10);
        check_eq("bp_second", (q1.size() > 1) ? q1[1] : 32'hDEADBEEF, 32'd14);
        for (int i = 0; i < 5; i++) @(negedge clk);
        check_eq("bp_no_dup", 32'(q1.size()), 32'd2);

        // Wrap-around on the 18-bit accumulator.
        @(posedge clk);
        #1;
        clear_q();
        send(ones, ones, 1'b0, 1'b0);
        send(ones, ones, 1'b1, 1'b0);
        guard = 0;
        while (q2.size() < 1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("wrap_count", 32'(q2.size()), 32'd1);
        check_eq("wrap18", (q2.size() > 0) ? q2[0] : 32'hDEADBEEF, 32'd258056);
        check_eq("nowrap32", (q1.size() > 0) ? q1[0] : 32'hDEADBEEF, 32'd520200);

        // Reset mid-window discards partial sum and in-flight beats.
        @(posedge clk);
        #1;
        clear_q();
        send(ten_a, unit, 1'b0, 1'b0);
        send(ten_a, unit, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_ov", {31'd0, out_valid}, 32'd0);
        check_eq("rst_mid_acc_out", acc_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_q();
        send(pk(8'd5, 8'd0, 8'd0, 8'd0), unit, 1'b1, 1'b0);
        wait_q1(1, "rst_fresh_count");
        check_eq("rst_fresh_sum", (q1.size() > 0) ? q1[0] : 32'hDEADBEEF, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
